// File: rtl/demux1_8_deserializer.sv
// Serial-in / parallel-out deserializer. A bit index acts as a 1:WIDTH demux
// select that steers each accepted serial bit into an assembly register. A
// completed word moves into a holding register offered under valid/ready.
module demux1_8_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] assembly;
  logic [WIDTH-1:0] merged;
  logic [IW-1:0]    pos;
  logic             last;
  logic             acc;

  // WIDTH is a power of two, so WIDTH-1-idx is the bitwise complement of idx.
  assign pos      = MSB_FIRST ? ~idx : idx;
  assign last     = &idx;
  // Only the completing bit has to wait for the held word to be taken.
  assign in_ready = ~(out_valid & ~out_ready & last);
  assign acc      = in_valid & in_ready & ~clear;
  assign bit_idx  = idx;

  // Assembly register with the incoming bit dropped into the selected slot.
  always_comb begin
    merged      = assembly;
    merged[pos] = in_bit;
  end

  // Bit index and partial word; clear wins over an accept in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      assembly <= '0;
    end else if (clear) begin
      idx      <= '0;
      assembly <= '0;
    end else if (acc) begin
      if (last) begin
        idx      <= '0;
        assembly <= '0;
      end else begin
        idx      <= idx + 1'b1;
        assembly <= merged;
      end
    end
  end

  // Holding register: a completion reloads it even while the old word drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (acc && last) begin
      out_word  <= merged;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux1_8_deserializer.sv
// Bench for demux1_8_deserializer: an LSB-first and an MSB-first instance
// share one input stream and are compared every cycle against a queue-based
// reference model of the word assembly and output handshake.
module tb_demux1_8_deserializer;

  logic       clk;
  logic       reset_n;
  logic       in_bit;
  logic       in_valid;
  logic       clear;
  logic       out_ready;
  logic       in_ready_l, in_ready_m;
  logic [7:0] out_word_l, out_word_m;
  logic       out_valid_l, out_valid_m;
  logic [2:0] bit_idx_l, bit_idx_m;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit       q[$];
  bit [7:0] m_word_l, m_word_m;
  bit       m_valid;
  bit       m_acc;

  demux1_8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_l), .clear(clear), .out_word(out_word_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .bit_idx(bit_idx_l)
  );

  demux1_8_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_m), .clear(clear), .out_word(out_word_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .bit_idx(bit_idx_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_word_l = '0;
    m_word_m = '0;
    m_valid  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid_l"}, out_valid_l, m_valid);
    check({tag, ".valid_m"}, out_valid_m, m_valid);
    check({tag, ".word_l"},  out_word_l,  m_word_l);
    check({tag, ".word_m"},  out_word_m,  m_word_m);
    check({tag, ".idx_l"},   bit_idx_l,   q.size());
    check({tag, ".idx_m"},   bit_idx_m,   q.size());
  endtask

  // One clock: drive inputs, check at negedge, advance the model, pass posedge.
  task automatic cycle(input bit v, input bit b, input bit clr, input bit ordy);
    bit rdy;
    in_valid  = v;
    in_bit    = b;
    clear     = clr;
    out_ready = ordy;
    @(negedge clk);
    rdy = !(m_valid && !ordy && q.size() == 7);
    check_state("cyc");
    check("cyc.ready_l", in_ready_l, rdy);
    check("cyc.ready_m", in_ready_m, rdy);
    m_acc = v && rdy && !clr;
    if (clr) begin
      q.delete();
    end else if (m_acc) begin
      q.push_back(b);
    end
    if (q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        m_word_l[k]     = q[k];
        m_word_m[7 - k] = q[k];
      end
      m_valid = 1'b1;
      q.delete();
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Present a bit until taken, holding it as the link protocol requires.
  task automatic send_bit(input bit b, input bit ordy);
    int tries = 0;
    do begin
      cycle(1'b1, b, 1'b0, ordy);
      tries++;
    end while (!m_acc && tries < 20);
    if (!m_acc) check("send_bit.timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [7:0] w, input bit ordy);
    for (int k = 0; k < 8; k++) send_bit(w[k], ordy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w;
    reset_n   = 1'b0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", out_valid_l, 1'b0);
    check("reset.word",  out_word_l,  8'h00);
    check("reset.idx",   bit_idx_l,   3'd0);
    reset_n = 1'b1;
    check("reset.ready", in_ready_l,  1'b1);

    // LSB-first 0,0,1,1,0,0,1,1 -> CC; MSB-first instance sees the same bits -> 33
    w = 8'hCC;
    for (int k = 0; k < 8; k++) cycle(1'b1, w[k], 1'b0, 1'b1);
    check("t1.word_l", out_word_l, 8'hCC);
    check("t1.valid",  out_valid_l, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1.pulse",  out_valid_l, 1'b0);

    // bits 1,0,1,0,... into the MSB-first instance give AA, then 55
    w = 8'h55;
    send_word(w, 1'b1);
    check("t2.word_m_aa", out_word_m, 8'hAA);
    w = 8'hAA;
    send_word(w, 1'b1);
    check("t2.word_m_55", out_word_m, 8'h55);
    idle(2);

    // backpressure: F0 held, 0F stalls on its last bit, then loads with drain
    send_word(8'hF0, 1'b0);
    w = 8'h0F;
    for (int k = 0; k < 7; k++) send_bit(w[k], 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, w[7], 1'b0, 1'b0);
      check("t3.stall_ready", in_ready_l, 1'b0);
      check("t3.stall_idx",   bit_idx_l,  3'd7);
      check("t3.held_word",   out_word_l, 8'hF0);
    end
    cycle(1'b1, w[7], 1'b0, 1'b1);
    check("t3.new_word", out_word_l, 8'h0F);
    check("t3.no_bubble", out_valid_l, 1'b1);
    idle(2);

    // clear discards a partial word of ones and the bit presented with it
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("t4.idx_cleared", bit_idx_l, 3'd0);
    send_word(8'h01, 1'b0);
    check("t4.word", out_word_l, 8'h01);

    // asynchronous reset mid-word with a held word present
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t5.valid", out_valid_l, 1'b0);
    check("t5.word",  out_word_l,  8'h00);
    check("t5.idx",   bit_idx_l,   3'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    send_word(8'h33, 1'b1);
    check("t5.after", out_word_l, 8'h33);
    idle(1);

    // gaps between bits
    w = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, w[k], 1'b0, 1'b1);
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    check("t6.word", out_word_l, 8'h0F);
    idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
